// File: rtl/bisr_pkg.sv
// Shared types and helpers for the spare-slot allocation logic.
package bisr_pkg;

   // Allocation FSM state encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_GRANT = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   // Number of one-hot positions an index of idx_w bits can address.
   function automatic int unsigned onehot_span(input int unsigned idx_w);
      return 32'd1 << idx_w;
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index-to-one-hot decoder; output is zero when en is low
// or when idx addresses a position at or beyond WIDTH.
module onehot_decoder
   import bisr_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [WIDTH-1:0] onehot
);

   localparam int unsigned SPAN = onehot_span(IDX_W);

   // Decode idx; positions the index cannot reach stay zero.
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i < SPAN) begin
            onehot[i] = en && (idx == IDX_W'(i));
         end
      end
   end

endmodule

// File: rtl/spare_map_decoder.sv
// Spare slot allocator: IDLE -> CHECK -> GRANT/ERR handshake FSM with an
// occupancy bitmap, independent release path and sticky error flag.
// Optional feature: define SPARE_MAP_FREE_COUNT_EN to add the free_cnt output.
module spare_map_decoder
   import bisr_pkg::*;
#(
   parameter  int unsigned OUTPUT_WIDTH = 4,
   localparam int unsigned IDX_W        = $clog2(OUTPUT_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alloc_valid,
   input  logic [IDX_W-1:0]        alloc_idx,
   output logic                    alloc_ready,
   input  logic                    rel_valid,
   input  logic [IDX_W-1:0]        rel_idx,
   output logic                    grant_valid,
   output logic [OUTPUT_WIDTH-1:0] grant_onehot,
   output logic [OUTPUT_WIDTH-1:0] occ_mask,
   output logic                    full,
   output logic                    err,
`ifdef SPARE_MAP_FREE_COUNT_EN
   output logic [IDX_W:0]          free_cnt,
`endif
   input  logic                    err_clr
);

   state_t                  state;
   logic [IDX_W-1:0]        cap_idx;
   logic [OUTPUT_WIDTH-1:0] cap_mask;
   logic [OUTPUT_WIDTH-1:0] rel_mask;
   logic [OUTPUT_WIDTH-1:0] set_mask;
   logic [OUTPUT_WIDTH-1:0] occ_next;
   logic                    check_ok;
   logic                    rel_ok;
   logic                    rel_bad;

   onehot_decoder #(.WIDTH(OUTPUT_WIDTH), .IDX_W(IDX_W)) u_cap_dec (
      .idx    (cap_idx),
      .en     (1'b1),
      .onehot (cap_mask)
   );

   onehot_decoder #(.WIDTH(OUTPUT_WIDTH), .IDX_W(IDX_W)) u_rel_dec (
      .idx    (rel_idx),
      .en     (rel_valid),
      .onehot (rel_mask)
   );

   assign alloc_ready = (state == ST_IDLE);
   assign full        = &occ_mask;

   // Decoder masks are zero for out-of-range indices, so a single AND
   // covers both the range check and the occupancy check.
   always_comb begin
      check_ok = |(cap_mask & ~occ_mask);
      rel_ok   = |(rel_mask & occ_mask);
      rel_bad  = rel_valid && !rel_ok;
      set_mask = (state == ST_GRANT) ? cap_mask : '0;
      occ_next = (occ_mask & ~rel_mask) | set_mask;
   end

   // Occupancy bitmap: release clears, grant sets, set wins on collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_mask <= '0;
      end else begin
         occ_mask <= occ_next;
      end
   end

`ifdef SPARE_MAP_FREE_COUNT_EN
   logic [IDX_W:0] free_next;

   // Count free slots in the next-state bitmap so free_cnt tracks occ_mask.
   always_comb begin
      free_next = '0;
      for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
         if (!occ_next[i]) begin
            free_next = free_next + (IDX_W+1)'(1);
         end
      end
   end

   // Registered free-slot count.
   always_ff @(posedge clk) begin
      if (rst) begin
         free_cnt <= (IDX_W+1)'(OUTPUT_WIDTH);
      end else begin
         free_cnt <= free_next;
      end
   end
`endif

   // Allocation FSM with registered grant outputs and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cap_idx      <= '0;
         grant_valid  <= 1'b0;
         grant_onehot <= '0;
         err          <= 1'b0;
      end else begin
         grant_valid  <= 1'b0;
         grant_onehot <= '0;
         case (state)
            ST_IDLE: begin
               if (alloc_valid) begin
                  cap_idx <= alloc_idx;
                  state   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               state <= check_ok ? ST_GRANT : ST_ERR;
            end
            ST_GRANT: begin
               grant_valid  <= 1'b1;
               grant_onehot <= cap_mask;
               state        <= ST_IDLE;
            end
            ST_ERR: begin
               if (err_clr) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (rel_bad || (state == ST_CHECK && !check_ok)) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spare_map_decoder.sv
// Directed self-checking bench for spare_map_decoder (W=4 and W=5 instances).
module tb_spare_map_decoder;

   logic       clk;
   logic       rst;

   logic       alloc_valid, rel_valid, err_clr;
   logic [1:0] alloc_idx, rel_idx;
   logic       alloc_ready, grant_valid, full, err;
   logic [3:0] grant_onehot, occ_mask;

   logic       a5_valid, r5_valid, c5_clr;
   logic [2:0] a5_idx, r5_idx;
   logic       ready5, gv5, full5, err5;
   logic [4:0] oh5, occ5;

`ifdef SPARE_MAP_FREE_COUNT_EN
   logic [2:0] free_cnt;
   logic [3:0] free5;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   spare_map_decoder #(.OUTPUT_WIDTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_valid  (alloc_valid),
      .alloc_idx    (alloc_idx),
      .alloc_ready  (alloc_ready),
      .rel_valid    (rel_valid),
      .rel_idx      (rel_idx),
      .grant_valid  (grant_valid),
      .grant_onehot (grant_onehot),
      .occ_mask     (occ_mask),
      .full         (full),
      .err          (err),
`ifdef SPARE_MAP_FREE_COUNT_EN
      .free_cnt     (free_cnt),
`endif
      .err_clr      (err_clr)
   );

   spare_map_decoder #(.OUTPUT_WIDTH(5)) dut5 (
      .clk          (clk),
      .rst          (rst),
      .alloc_valid  (a5_valid),
      .alloc_idx    (a5_idx),
      .alloc_ready  (ready5),
      .rel_valid    (r5_valid),
      .rel_idx      (r5_idx),
      .grant_valid  (gv5),
      .grant_onehot (oh5),
      .occ_mask     (occ5),
      .full         (full5),
      .err          (err5),
`ifdef SPARE_MAP_FREE_COUNT_EN
      .free_cnt     (free5),
`endif
      .err_clr      (c5_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_alloc(input logic [1:0] idx);
      alloc_valid = 1'b1;
      alloc_idx   = idx;
      tick();
      alloc_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (occ_mask !== 4'b0000) begin n_bad++; $display("FAIL reset_occ: got %b want 0000", occ_mask); end
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
      n_cmp++; if (grant_onehot !== 4'b0000) begin n_bad++; $display("FAIL reset_oh: got %b want 0000", grant_onehot); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
   endtask

   task automatic test_alloc_basic();
      alloc_valid = 1'b1;
      alloc_idx   = 2'd2;
      tick();
      n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_t0: got %b want 0", alloc_ready); end
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL basic_gv_t0: got %b want 0", grant_valid); end
      alloc_valid = 1'b0;
      tick();
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL basic_gv_t1: got %b want 0", grant_valid); end
      tick();
      n_cmp++; if (grant_valid !== 1'b1) begin n_bad++; $display("FAIL basic_gv_t2: got %b want 1", grant_valid); end
      n_cmp++; if (grant_onehot !== 4'b0100) begin n_bad++; $display("FAIL basic_oh: got %b want 0100", grant_onehot); end
      n_cmp++; if (occ_mask !== 4'b0100) begin n_bad++; $display("FAIL basic_occ: got %b want 0100", occ_mask); end
      n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_t2: got %b want 1", alloc_ready); end
      tick();
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL basic_gv_t3: got %b want 0", grant_valid); end
      n_cmp++; if (grant_onehot !== 4'b0000) begin n_bad++; $display("FAIL basic_oh_t3: got %b want 0000", grant_onehot); end
   endtask

   task automatic test_fill_and_dup();
      do_alloc(2'd0);
      do_alloc(2'd1);
      do_alloc(2'd3);
      n_cmp++; if (occ_mask !== 4'b1111) begin n_bad++; $display("FAIL fill_occ: got %b want 1111", occ_mask); end
      n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", full); end
      alloc_valid = 1'b1;
      alloc_idx   = 2'd1;
      tick();
      tick();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL dup_err: got %b want 1", err); end
      n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL dup_ready: got %b want 0", alloc_ready); end
      tick();
      tick();
      n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL dup_hold_ready: got %b want 0", alloc_ready); end
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL dup_hold_gv: got %b want 0", grant_valid); end
      n_cmp++; if (occ_mask !== 4'b1111) begin n_bad++; $display("FAIL dup_hold_occ: got %b want 1111", occ_mask); end
      alloc_valid = 1'b0;
      err_clr     = 1'b1;
      tick();
      err_clr = 1'b0;
      n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL dup_clr_ready: got %b want 1", alloc_ready); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL dup_clr_err: got %b want 0", err); end
   endtask

   task automatic test_set_wins();
      do_reset();
      alloc_valid = 1'b1;
      alloc_idx   = 2'd1;
      tick();
      alloc_valid = 1'b0;
      tick();
      rel_valid = 1'b1;
      rel_idx   = 2'd1;
      tick();
      rel_valid = 1'b0;
      n_cmp++; if (occ_mask !== 4'b0010) begin n_bad++; $display("FAIL setwin_occ: got %b want 0010", occ_mask); end
      n_cmp++; if (grant_valid !== 1'b1) begin n_bad++; $display("FAIL setwin_gv: got %b want 1", grant_valid); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL setwin_err: got %b want 1", err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL idle_clr_err: got %b want 0", err); end
      // Release during CHECK: CHECK still sees the bit as occupied.
      alloc_valid = 1'b1;
      alloc_idx   = 2'd1;
      tick();
      alloc_valid = 1'b0;
      rel_valid   = 1'b1;
      rel_idx     = 2'd1;
      tick();
      rel_valid = 1'b0;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL chkrel_err: got %b want 1", err); end
      n_cmp++; if (occ_mask !== 4'b0000) begin n_bad++; $display("FAIL chkrel_occ: got %b want 0000", occ_mask); end
      n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL chkrel_ready: got %b want 0", alloc_ready); end
      tick();
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL chkrel_gv: got %b want 0", grant_valid); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL chkrel_clr_ready: got %b want 1", alloc_ready); end
   endtask

   task automatic test_release_err();
      do_reset();
      rel_valid = 1'b1;
      rel_idx   = 2'd3;
      tick();
      rel_valid = 1'b0;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL relerr_err: got %b want 1", err); end
      n_cmp++; if (occ_mask !== 4'b0000) begin n_bad++; $display("FAIL relerr_occ: got %b want 0000", occ_mask); end
      n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL relerr_ready: got %b want 1", alloc_ready); end
   endtask

   task automatic test_reset_in_grant();
      do_reset();
      alloc_valid = 1'b1;
      alloc_idx   = 2'd0;
      tick();
      alloc_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL rstgr_gv: got %b want 0", grant_valid); end
      n_cmp++; if (occ_mask !== 4'b0000) begin n_bad++; $display("FAIL rstgr_occ: got %b want 0000", occ_mask); end
      tick();
      n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL rstgr_gv_after: got %b want 0", grant_valid); end
      n_cmp++; if (occ_mask !== 4'b0000) begin n_bad++; $display("FAIL rstgr_occ_after: got %b want 0000", occ_mask); end
      n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rstgr_ready: got %b want 1", alloc_ready); end
   endtask

`ifdef SPARE_MAP_FREE_COUNT_EN
   task automatic test_free_cnt();
      do_reset();
      n_cmp++; if (free_cnt !== 3'd4) begin n_bad++; $display("FAIL free_reset: got %0d want 4", free_cnt); end
      do_alloc(2'd3);
      n_cmp++; if (free_cnt !== 3'd3) begin n_bad++; $display("FAIL free_grant: got %0d want 3", free_cnt); end
      rel_valid = 1'b1;
      rel_idx   = 2'd3;
      tick();
      rel_valid = 1'b0;
      n_cmp++; if (free_cnt !== 3'd4) begin n_bad++; $display("FAIL free_release: got %0d want 4", free_cnt); end
      n_cmp++; if (occ_mask !== 4'b0000) begin n_bad++; $display("FAIL free_occ: got %b want 0000", occ_mask); end
   endtask
`endif

   task automatic test_out_of_range();
      do_reset();
      a5_valid = 1'b1;
      a5_idx   = 3'd4;
      tick();
      a5_valid = 1'b0;
      tick();
      tick();
      n_cmp++; if (occ5 !== 5'b10000) begin n_bad++; $display("FAIL w5_occ: got %b want 10000", occ5); end
      n_cmp++; if (oh5 !== 5'b10000) begin n_bad++; $display("FAIL w5_oh: got %b want 10000", oh5); end
      a5_valid = 1'b1;
      a5_idx   = 3'd6;
      tick();
      a5_valid = 1'b0;
      tick();
      n_cmp++; if (err5 !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b want 1", err5); end
      n_cmp++; if (ready5 !== 1'b0) begin n_bad++; $display("FAIL oor_ready: got %b want 0", ready5); end
      n_cmp++; if (occ5 !== 5'b10000) begin n_bad++; $display("FAIL oor_occ: got %b want 10000", occ5); end
      tick();
      n_cmp++; if (gv5 !== 1'b0) begin n_bad++; $display("FAIL oor_gv: got %b want 0", gv5); end
      c5_clr = 1'b1;
      tick();
      c5_clr = 1'b0;
      n_cmp++; if (ready5 !== 1'b1) begin n_bad++; $display("FAIL oor_clr_ready: got %b want 1", ready5); end
      n_cmp++; if (err5 !== 1'b0) begin n_bad++; $display("FAIL oor_clr_err: got %b want 0", err5); end
   endtask

   initial begin
      rst         = 1'b1;
      alloc_valid = 1'b0;
      alloc_idx   = '0;
      rel_valid   = 1'b0;
      rel_idx     = '0;
      err_clr     = 1'b0;
      a5_valid    = 1'b0;
      a5_idx      = '0;
      r5_valid    = 1'b0;
      r5_idx      = '0;
      c5_clr      = 1'b0;
      tick();
      test_reset();
      test_alloc_basic();
      test_fill_and_dup();
      test_set_wins();
      test_release_err();
      test_reset_in_grant();
`ifdef SPARE_MAP_FREE_COUNT_EN
      test_free_cnt();
`endif
      test_out_of_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spare_map_decoder.md
SPARE_MAP_DECODER -- requirements
Module: spare_map_decoder

Interface
REQ-001 SHALL have parameter OUTPUT_WIDTH, default 4, meaning number of spare slots tracked (>=2).
REQ-002 SHALL have derived constant IDX_W = $clog2(OUTPUT_WIDTH), the width of slot indices.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alloc_valid  input  1  allocation request present.
REQ-006 SHALL have port alloc_idx  input  IDX_W  encoded slot to allocate.
REQ-007 SHALL have port alloc_ready  output  1  block can accept a request.
REQ-008 SHALL have port rel_valid  input  1  release request, no backpressure.
REQ-009 SHALL have port rel_idx  input  IDX_W  encoded slot to release.
REQ-010 SHALL have port grant_valid  output  1  one-cycle pulse: allocation committed.
REQ-011 SHALL have port grant_onehot  output  OUTPUT_WIDTH  decoded one-hot of the committed slot.
REQ-012 SHALL have port occ_mask  output  OUTPUT_WIDTH  registered occupancy bitmap, bit i = slot i in use.
REQ-013 SHALL have port full  output  1  all occ_mask bits set.
REQ-014 SHALL have port err  output  1  sticky error flag.
REQ-015 SHALL have port err_clr  input  1  clears err and returns FSM to IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, GRANT, ERR.
REQ-017 SHALL assert alloc_ready only in IDLE; handshake = alloc_valid && alloc_ready, alloc_idx captured on that edge, IDLE->CHECK.
REQ-018 SHALL in CHECK go to ERR if captured idx >= OUTPUT_WIDTH or occ_mask bit already set; otherwise to GRANT.
REQ-019 SHALL in GRANT set occ_mask bit, drive grant_valid=1 and grant_onehot=1<<idx for exactly one cycle, then IDLE.
REQ-020 SHALL give latency: handshake at edge T, grant_valid high in the cycle after edge T+2; next handshake no earlier than edge T+3.
REQ-021 SHALL drive grant_onehot to all-zero whenever grant_valid is 0.
REQ-022 SHALL clear occ_mask[rel_idx] on any edge with rel_valid=1, in any state, independent of the alloc FSM.
REQ-023 SHALL, on release of an unoccupied or out-of-range index, set err without altering occ_mask or FSM state.
REQ-024 SHALL, when GRANT set and release clear hit the same bit on the same edge, leave the bit set (set wins).
REQ-025 SHALL, when release clears the bit under test during CHECK, evaluate CHECK against occ_mask as registered before that edge.
REQ-026 SHALL hold ERR with err=1 and alloc_ready=0 until err_clr; err_clr returns to IDLE next edge; err_clr outside ERR only clears err.
REQ-027 SHALL derive full combinationally from occ_mask; full does not block alloc_ready (duplicate alloc goes to ERR).

Reset
REQ-028 SHALL on rst: state=IDLE, occ_mask=0, grant_valid=0, grant_onehot=0, err=0, captured idx=0; alloc_ready=1 the first cycle after reset deasserts.
REQ-029 SHALL let rst override all inputs including rel_valid and err_clr; reset mid-CHECK/GRANT discards the pending grant.

Configuration
REQ-030 SHALL, with SPARE_MAP_FREE_COUNT_EN defined, add output free_cnt (IDX_W+1 bits) = count of zero bits in occ_mask, registered, reset OUTPUT_WIDTH, updated same edge as occ_mask.
REQ-031 SHALL, without SPARE_MAP_FREE_COUNT_EN, omit the free_cnt port and its logic entirely.

Structure
REQ-032 SHALL place the FSM state enum (2-bit) and an idx-to-onehot width helper in shared package bisr_pkg.
REQ-033 SHALL use one sub-module onehot_decoder (combinational, index -> one-hot, zero when enable low), instantiated for grant_onehot and reused for release/set masks.

Verification
REQ-034 SHALL cover: reset, alloc idx 2 (W=4) -> grant_valid 2 cycles after handshake, grant_onehot=4'b0100, occ_mask=4'b0100.
REQ-035 SHALL cover: alloc 0,1,2,3 -> occ_mask=4'b1111, full=1; alloc 1 again -> err=1, alloc_ready=0 until err_clr.
REQ-036 SHALL cover: W=5, alloc_idx=6 -> ERR, occ_mask unchanged; err_clr -> IDLE, alloc_ready=1 next cycle.
REQ-037 SHALL cover: occ_mask=4'b0010, GRANT idx 1 coincident with rel_idx 1 -> occ_mask bit1 stays 1.
REQ-038 SHALL cover: release idx 3 with occ_mask=0 -> err=1, occ_mask=0, FSM still IDLE; rst during GRANT -> grant_valid=0, occ_mask=0.
REQ-039 SHALL cover (with SPARE_MAP_FREE_COUNT_EN): free_cnt 4 after reset, 3 after one grant, 4 after release.
